// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer and its frame timer.
package pong_pkg;

  localparam int SCORE_W = 4;

  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;

  localparam logic [1:0] SPEED_MAX = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SERVE_WAIT = 3'd1,
    S_RALLY      = 3'd2,
    S_POINT      = 3'd3,
    S_GAME_OVER  = 3'd4
  } state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value,
                                                 input logic [SCORE_W-1:0] limit);
    return (value >= limit) ? limit : value + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// 8-bit frame down-counter shared by the serve delay and the point flash.
// A load always wins over a coincident tick; the count holds at zero.
module pong_frame_timer (
  input  logic       VGA_CLOCK,
  input  logic       RESET,
  input  logic       LOAD,
  input  logic [7:0] LOAD_VALUE,
  input  logic       TICK,
  output logic       DONE
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (LOAD) begin
      count_d = LOAD_VALUE;
    end else if (TICK && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign DONE = (count_q == 8'd0);

endmodule

// File: rtl/pong_match_controller.sv
// Pong match sequencer: serve / rally / point / game-over flow and both scores.
// Optional ball speed-up on paddle hits is built only when PONG_SPEEDUP_EN is defined.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE      = 11,
  parameter int SERVE_FRAMES   = 120,
  parameter int POINT_FRAMES   = 60,
  parameter int HITS_PER_LEVEL = 4
) (
  input  logic               VGA_CLOCK,
  input  logic               RESET,
  input  logic               FRAME_TICK,
  input  logic               START,
  input  logic               MISS_A,
  input  logic               MISS_B,
  input  logic               PADDLE_HIT,
  output logic               BALL_ENABLE,
  output logic               SERVE,
  output logic               SERVE_DIR,
  output logic               BALL_VISIBLE,
  output logic [SCORE_W-1:0] SCORE_A,
  output logic [SCORE_W-1:0] SCORE_B,
  output logic               GAME_OVER,
  output logic               WINNER,
  output logic [1:0]         SPEED_LEVEL
);

  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic               dir_q, dir_d;
  logic               odd_q, odd_d;
  logic               start_q;
  logic               start_rise;
  logic               serve;
  logic               timer_load;
  logic [7:0]         timer_value;
  logic               timer_done;

  assign start_rise = START & ~start_q;

  pong_frame_timer u_timer (
    .VGA_CLOCK  (VGA_CLOCK),
    .RESET      (RESET),
    .LOAD       (timer_load),
    .LOAD_VALUE (timer_value),
    .TICK       (FRAME_TICK),
    .DONE       (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    dir_d       = dir_q;
    odd_d       = odd_q;
    serve       = 1'b0;
    timer_load  = 1'b0;
    timer_value = 8'(SERVE_FRAMES);

    unique case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_rise) begin
          state_d    = S_SERVE_WAIT;
          score_a_d  = '0;
          score_b_d  = '0;
          dir_d      = DIR_A;
          timer_load = 1'b1;
        end
      end
      S_SERVE_WAIT: begin
        if (timer_done) begin
          serve   = 1'b1;
          state_d = S_RALLY;
        end
      end
      S_RALLY: begin
        // MISS_A has priority when both paddles report a miss together.
        if (MISS_A || MISS_B) begin
          state_d     = S_POINT;
          odd_d       = 1'b0;
          timer_load  = 1'b1;
          timer_value = 8'(POINT_FRAMES);
          if (MISS_A) begin
            score_b_d = sat_inc(score_b_q, WIN);
            dir_d     = DIR_A;
          end else begin
            score_a_d = sat_inc(score_a_q, WIN);
            dir_d     = DIR_B;
          end
        end
      end
      S_POINT: begin
        if (timer_done) begin
          if ((score_a_q == WIN) || (score_b_q == WIN)) begin
            state_d = S_GAME_OVER;
          end else begin
            state_d    = S_SERVE_WAIT;
            timer_load = 1'b1;
          end
        end else if (FRAME_TICK) begin
          odd_d = ~odd_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: only control registers are reset here; there are no memories to clear.
  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      score_a_q <= '0;
      score_b_q <= '0;
      dir_q     <= DIR_A;
      odd_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      dir_q     <= dir_d;
      odd_q     <= odd_d;
      start_q   <= START;
    end
  end

  assign BALL_ENABLE  = (state_q == S_RALLY);
  assign SERVE        = serve;
  assign SERVE_DIR    = dir_q;
  assign BALL_VISIBLE = (state_q == S_SERVE_WAIT) || (state_q == S_RALLY) ||
                        ((state_q == S_POINT) && !odd_q);
  assign SCORE_A      = score_a_q;
  assign SCORE_B      = score_b_q;
  assign GAME_OVER    = (state_q == S_GAME_OVER);
  assign WINNER       = (state_q == S_GAME_OVER) && (score_b_q == WIN);

`ifdef PONG_SPEEDUP_EN
  logic [7:0] hit_cnt_q, hit_cnt_d;
  logic [1:0] speed_q, speed_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    speed_d   = speed_q;
    if (serve) begin
      hit_cnt_d = '0;
      speed_d   = '0;
    end else if ((state_q == S_RALLY) && PADDLE_HIT) begin
      if (hit_cnt_q == 8'(HITS_PER_LEVEL - 1)) begin
        hit_cnt_d = '0;
        if (speed_q != SPEED_MAX) begin
          speed_d = speed_q + 2'd1;
        end
      end else begin
        hit_cnt_d = hit_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      hit_cnt_q <= '0;
      speed_q   <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      speed_q   <= speed_d;
    end
  end

  assign SPEED_LEVEL = speed_q;
`else
  logic unused_paddle_hit;
  assign unused_paddle_hit = PADDLE_HIT;
  assign SPEED_LEVEL       = 2'b00;
`endif

endmodule

// File: tb/tb_pong_match_controller.sv
// Self-checking bench for pong_match_controller: directed vector table, corner
// sequences and random stimulus against a behavioural match model.
module tb_pong_match_controller;

  localparam int WIN = 3;
  localparam int SF  = 3;
  localparam int PF  = 2;
  localparam int HPL = 2;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_RALLY = 2;
  localparam int M_POINT = 3;
  localparam int M_OVER  = 4;

  logic       clk = 1'b0;
  logic       rst, start, tick, miss_a, miss_b, hit;
  logic       ben, serve, dir, vis, go, win;
  logic [3:0] sa, sb;
  logic [1:0] spd;

  int checks = 0;
  int errors = 0;

  int m_mode, m_frames, m_sa, m_sb, m_dir, m_odd, m_prev_start, m_hits, m_level;

  always #5 clk = ~clk;

  pong_match_controller #(
    .WIN_SCORE      (WIN),
    .SERVE_FRAMES   (SF),
    .POINT_FRAMES   (PF),
    .HITS_PER_LEVEL (HPL)
  ) dut (
    .VGA_CLOCK    (clk),
    .RESET        (rst),
    .FRAME_TICK   (tick),
    .START        (start),
    .MISS_A       (miss_a),
    .MISS_B       (miss_b),
    .PADDLE_HIT   (hit),
    .BALL_ENABLE  (ben),
    .SERVE        (serve),
    .SERVE_DIR    (dir),
    .BALL_VISIBLE (vis),
    .SCORE_A      (sa),
    .SCORE_B      (sb),
    .GAME_OVER    (go),
    .WINNER       (win),
    .SPEED_LEVEL  (spd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Match rules applied one clock at a time with plain integer bookkeeping.
  task automatic model_step(input logic r, s, t, a, b, h);
    bit rise;
    if (r) begin
      m_mode = M_IDLE; m_frames = 0; m_sa = 0; m_sb = 0; m_dir = 0;
      m_odd = 0; m_prev_start = 0; m_hits = 0; m_level = 0;
      return;
    end
    rise = s && !m_prev_start;
    m_prev_start = s;
    case (m_mode)
      M_IDLE, M_OVER: if (rise) begin
        m_sa = 0; m_sb = 0; m_dir = 0; m_mode = M_WAIT; m_frames = SF;
      end
      M_WAIT: begin
        if (m_frames == 0) begin
          m_mode = M_RALLY; m_hits = 0; m_level = 0;
        end else if (t) m_frames--;
      end
      M_RALLY: begin
        if (h) begin
          m_hits++;
          if (m_hits == HPL) begin
            m_hits = 0;
            if (m_level < 3) m_level++;
          end
        end
        if (a) begin
          m_sb = (m_sb < WIN) ? m_sb + 1 : WIN;
          m_dir = 0; m_mode = M_POINT; m_frames = PF; m_odd = 0;
        end else if (b) begin
          m_sa = (m_sa < WIN) ? m_sa + 1 : WIN;
          m_dir = 1; m_mode = M_POINT; m_frames = PF; m_odd = 0;
        end
      end
      M_POINT: begin
        if (m_frames == 0) begin
          if (m_sa == WIN || m_sb == WIN) m_mode = M_OVER;
          else begin
            m_mode = M_WAIT; m_frames = SF;
          end
        end else if (t) begin
          m_frames--; m_odd = !m_odd;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  function automatic logic [15:0] model_out();
    logic [1:0] spd_e;
`ifdef PONG_SPEEDUP_EN
    spd_e = 2'(m_level);
`else
    spd_e = 2'd0;
`endif
    return {(m_mode == M_WAIT) && (m_frames == 0), m_mode == M_RALLY, m_dir != 0,
            (m_mode == M_WAIT) || (m_mode == M_RALLY) || ((m_mode == M_POINT) && (m_odd == 0)),
            m_mode == M_OVER, (m_mode == M_OVER) && (m_sb == WIN),
            4'(m_sa), 4'(m_sb), spd_e};
  endfunction

  function automatic logic [15:0] dut_out();
    return {serve, ben, dir, vis, go, win, sa, sb, spd};
  endfunction

  task automatic step(input logic r, s, t, a, b, h);
    rst = r; start = s; tick = t; miss_a = a; miss_b = b; hit = h;
    model_step(r, s, t, a, b, h);
    @(posedge clk);
    #1;
    check("model", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic run_to_rally();
    int n = 0;
    while (ben !== 1'b1 && n < 40) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("reach_rally", 32'(ben), 32'd1);
  endtask

  typedef struct packed {
    logic [5:0] in;   // {rst, start, tick, miss_a, miss_b, hit}
    logic [3:0] ctl;  // {serve, ball_enable, serve_dir, ball_visible}
    logic [3:0] sa;
    logic [3:0] sb;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [1:0] exp_spd;
    logic       s_lvl;
    int         n;

`ifdef PONG_SPEEDUP_EN
    exp_spd = 2'd2;
`else
    exp_spd = 2'd0;
`endif

    rst = 1'b1; start = 1'b0; tick = 1'b0; miss_a = 1'b0; miss_b = 1'b0; hit = 1'b0;

    tbl[0]  = '{6'b100000, 4'b0000, 4'd0, 4'd0};  // reset
    tbl[1]  = '{6'b011000, 4'b0001, 4'd0, 4'd0};  // start rise with tick: load wins
    tbl[2]  = '{6'b011000, 4'b0001, 4'd0, 4'd0};  // start held: no re-trigger
    tbl[3]  = '{6'b011000, 4'b0001, 4'd0, 4'd0};
    tbl[4]  = '{6'b001000, 4'b1001, 4'd0, 4'd0};  // counter reaches 0: serve
    tbl[5]  = '{6'b000000, 4'b0101, 4'd0, 4'd0};  // rally
    tbl[6]  = '{6'b010000, 4'b0101, 4'd0, 4'd0};  // start in rally ignored
    tbl[7]  = '{6'b001010, 4'b0011, 4'd1, 4'd0};  // miss B
    tbl[8]  = '{6'b001000, 4'b0010, 4'd1, 4'd0};  // flash off
    tbl[9]  = '{6'b001000, 4'b0011, 4'd1, 4'd0};
    tbl[10] = '{6'b001000, 4'b0011, 4'd1, 4'd0};  // back to serve wait
    tbl[11] = '{6'b001100, 4'b0011, 4'd1, 4'd0};  // miss outside rally ignored
    tbl[12] = '{6'b001000, 4'b0011, 4'd1, 4'd0};
    tbl[13] = '{6'b001000, 4'b1011, 4'd1, 4'd0};  // serve toward B
    tbl[14] = '{6'b000000, 4'b0111, 4'd1, 4'd0};
    tbl[15] = '{6'b000110, 4'b0001, 4'd1, 4'd1};  // both misses: A wins

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].in[5], tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      check($sformatf("vec%0d_ctl", i), 32'({serve, ben, dir, vis}), 32'(tbl[i].ctl));
      check($sformatf("vec%0d_sa", i), 32'(sa), 32'(tbl[i].sa));
      check($sformatf("vec%0d_sb", i), 32'(sb), 32'(tbl[i].sb));
    end

    // Play two more A misses to finish the match in B's favour.
    for (int k = 0; k < 2; k++) begin
      run_to_rally();
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("sb_at_win", 32'(sb), 32'd3);
    n = 0;
    while (go !== 1'b1 && n < 40) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("game_over", 32'(go), 32'd1);
    check("winner_b", 32'(win), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("over_sa_hold", 32'(sa), 32'd1);
    check("over_sb_hold", 32'(sb), 32'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_sa", 32'(sa), 32'd0);
    check("restart_sb", 32'(sb), 32'd0);
    check("restart_over", 32'(go), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Speed-up: five hits give level 2, next serve clears it.
    run_to_rally();
    check("first_dir", 32'(dir), 32'd0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("speed_after_hits", 32'(spd), 32'(exp_spd));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_to_rally();
    check("speed_after_serve", 32'(spd), 32'd0);

    // Reset in POINT with SCORE_A = 2.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_to_rally();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("point_sa2", 32'(sa), 32'd2);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_all_zero", 32'(dut_out()), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_no_serve", 32'({serve, ben}), 32'd0);

    // Random play against the model.
    s_lvl = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) s_lvl = ~s_lvl;
      step($urandom_range(0, 299) == 0, s_lvl,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
